// File: rtl/fa_serial_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding,
// default operand width and a width helper for the bit counter.
package fa_serial_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Ceiling log2, never less than one bit so a WIDTH=1 counter still exists.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fa.sv
// 1-bit full adder cell; the single arithmetic element of the serial adder.
module fa (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/fa_serial_ctrl.sv
// Bit-serial adder: one fa cell stepped LSB-first, one bit per clock, with the
// carry held in a register between steps and the result latched on completion.
module fa_serial_ctrl
    import fa_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = clog2_min1(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [WIDTH-1:0] res_sh_d;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_sum;
    logic             fa_cout;

    fa u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (c_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // New sum bit enters at the MSB so after WIDTH steps the LSB lines up at bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_sh_d = fa_sum;
        end else begin : g_res_wn
            assign res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        c_q      <= cin;
                        cnt_q    <= '0;
                        res_sh_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_sh_q <= res_sh_d;
                    c_q      <= fa_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    // Result is latched while entering DONE so it is valid alongside done.
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= res_sh_d;
                        cout_q  <= fa_cout;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
